// File: rtl/mux4_rr_sched_if.sv
// Bundle of the request/data/grant/output signals of mux4_rr_sched.
//   master : requester/consumer side (drives req, a..d, y_ready; watches grant and y)
//   slave  : scheduler side (drives gnt, s1:s0, y, y_valid, busy)
// Optional feature macro: MUX4_SCHED_LOCK_EN adds the 1-bit lock signal.
interface mux4_rr_sched_if #(
    parameter int unsigned DW = 8
);
    logic [3:0]    req;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [DW-1:0] d;
    logic [3:0]    gnt;
    logic          s0;
    logic          s1;
    logic [DW-1:0] y;
    logic          y_valid;
    logic          y_ready;
    logic          busy;
`ifdef MUX4_SCHED_LOCK_EN
    logic          lock;

    modport master (
        output req, a, b, c, d, y_ready, lock,
        input  gnt, s0, s1, y, y_valid, busy
    );
    modport slave (
        input  req, a, b, c, d, y_ready, lock,
        output gnt, s0, s1, y, y_valid, busy
    );
`else
    modport master (
        output req, a, b, c, d, y_ready,
        input  gnt, s0, s1, y, y_valid, busy
    );
    modport slave (
        input  req, a, b, c, d, y_ready,
        output gnt, s0, s1, y, y_valid, busy
    );
`endif
endinterface

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing one 4:1 mux between requesters a,b,c,d.
// Drives the mux select s1:s0 and a one-hot grant, captures the selected data
// into a registered valid/ready output stage, and caps each grant at HOLD_MAX beats.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mux4_rr_sched_if.slave (req, a..d, y_ready in; gnt, s0, s1, y, y_valid, busy out)
// Optional feature macro: MUX4_SCHED_LOCK_EN -- bus.lock=1 suppresses the HOLD_MAX release.
module mux4_rr_sched #(
    parameter int unsigned DW       = 8,
    parameter int unsigned HOLD_MAX = 4
) (
    input logic               clk,
    input logic               rst_n,
    mux4_rr_sched_if.slave    bus
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [3:0] HoldMax = 4'(HOLD_MAX);

    state_e        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    beat_cnt_q, beat_cnt_d;
    logic [DW-1:0] y_q, y_d;
    logic          y_valid_q, y_valid_d;

    logic          take;
    logic          beat;
    logic          lock_hold;
    logic [1:0]    pick;
    logic [DW-1:0] mux_out;
    logic [3:0]    cnt_inc;

`ifdef MUX4_SCHED_LOCK_EN
    assign lock_hold = bus.lock;
`else
    assign lock_hold = 1'b0;
`endif

    // Output stage can accept a beat when empty or being drained this cycle.
    assign take = !y_valid_q || bus.y_ready;
    assign beat = (state_q == StGrant) && bus.req[idx_q] && take;

    // Saturate so a long locked grant cannot wrap back below HOLD_MAX.
    assign cnt_inc = (beat_cnt_q == 4'hF) ? 4'hF : beat_cnt_q + 4'd1;

    // First set request at or after ptr; scan backwards so the nearest one wins.
    always_comb begin
        pick = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[ptr_q + 2'(k)]) begin
                pick = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        unique case (idx_q)
            2'd0:    mux_out = bus.a;
            2'd1:    mux_out = bus.b;
            2'd2:    mux_out = bus.c;
            default: mux_out = bus.d;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        beat_cnt_d = beat_cnt_q;
        y_d        = y_q;
        y_valid_d  = y_valid_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req != 4'b0000) begin
                    state_d    = StGrant;
                    idx_d      = pick;
                    beat_cnt_d = 4'd0;
                end
            end
            StGrant: begin
                if (!bus.req[idx_q]) begin
                    state_d = StIdle;
                    ptr_d   = idx_q + 2'd1;
                end else if (take) begin
                    beat_cnt_d = cnt_inc;
                    if ((cnt_inc >= HoldMax) && !lock_hold) begin
                        state_d = StIdle;
                        ptr_d   = idx_q + 2'd1;
                    end
                end
                // A stall (take=0) holds the grant with the count frozen.
            end
            default: state_d = StIdle;
        endcase

        if (beat) begin
            y_d       = mux_out;
            y_valid_d = 1'b1;
        end else if (y_valid_q && bus.y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= 2'd0;
            idx_q      <= 2'd0;
            beat_cnt_q <= 4'd0;
            y_q        <= '0;
            y_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            beat_cnt_q <= beat_cnt_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
        end
    end

    // Select comes straight from the granted index, so it holds through IDLE.
    assign bus.gnt     = (state_q == StGrant) ? (4'b0001 << idx_q) : 4'b0000;
    assign bus.s0      = idx_q[0];
    assign bus.s1      = idx_q[1];
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.busy    = (state_q == StGrant);

endmodule

// File: tb/tb_mux4_rr_sched.sv
module tb_mux4_rr_sched;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [7:0] src_data [4];

    mux4_rr_sched_if #(.DW(8)) bus ();

    mux4_rr_sched #(.DW(8), .HOLD_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        src_data[0] = 8'h11;
        src_data[1] = 8'hA5;
        src_data[2] = 8'h33;
        src_data[3] = 8'h44;
        rst_n       = 1'b0;
        bus.req     = 4'b0000;
        bus.a       = src_data[0];
        bus.b       = src_data[1];
        bus.c       = src_data[2];
        bus.d       = src_data[3];
        bus.y_ready = 1'b1;
`ifdef MUX4_SCHED_LOCK_EN
        bus.lock    = 1'b0;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", bus.gnt, 4'b0000);
        check("rst_sel", {bus.s1, bus.s0}, 2'b00);
        check("rst_y", bus.y, 8'h00);
        check("rst_yv", bus.y_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single source b: 1-cycle grant latency, 4 beats, dead cycle, re-grant
        bus.req = 4'b0010;
        tick();
        check("sb_gnt", bus.gnt, 4'b0010);
        check("sb_sel", {bus.s1, bus.s0}, 2'b01);
        check("sb_busy", bus.busy, 1'b1);
        check("sb_yv0", bus.y_valid, 1'b0);
        tick();
        check("sb_y", bus.y, 8'hA5);
        check("sb_yv1", bus.y_valid, 1'b1);
        check("sb_gnt2", bus.gnt, 4'b0010);
        tick();
        tick();
        check("sb_gnt4", bus.gnt, 4'b0010);
        tick();
        check("sb_rel_gnt", bus.gnt, 4'b0000);
        check("sb_rel_busy", bus.busy, 1'b0);
        check("sb_rel_sel", {bus.s1, bus.s0}, 2'b01);
        check("sb_rel_yv", bus.y_valid, 1'b1);
        tick();
        check("sb_regnt", bus.gnt, 4'b0010);
        check("sb_drain_yv", bus.y_valid, 1'b0);
        bus.req = 4'b0000;
        tick();
        check("sb_drop_gnt", bus.gnt, 4'b0000);

        // Backpressure on a: one beat, then 5 stalled cycles, then 3 more beats
        bus.req = 4'b0001;
        bus.a   = 8'h5A;
        tick();
        check("bp_gnt", bus.gnt, 4'b0001);
        bus.y_ready = 1'b0;
        tick();
        check("bp_y", bus.y, 8'h5A);
        check("bp_yv", bus.y_valid, 1'b1);
        bus.a = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_stall_yv", bus.y_valid, 1'b1);
            check("bp_stall_y", bus.y, 8'h5A);
            check("bp_stall_gnt", bus.gnt, 4'b0001);
        end
        bus.y_ready = 1'b1;
        tick();
        check("bp_y2", bus.y, 8'hEE);
        check("bp_gnt2", bus.gnt, 4'b0001);
        tick();
        check("bp_gnt3", bus.gnt, 4'b0001);
        tick();
        check("bp_rel", bus.gnt, 4'b0000);

        // Early release of c after 2 beats with d pending
        bus.req = 4'b1100;
        tick();
        check("er_gnt_c", bus.gnt, 4'b0100);
        check("er_sel_c", {bus.s1, bus.s0}, 2'b10);
        tick();
        check("er_y", bus.y, 8'h33);
        tick();
        bus.req = 4'b1000;
        tick();
        check("er_rel", bus.gnt, 4'b0000);
        check("er_hold_sel", {bus.s1, bus.s0}, 2'b10);
        check("er_yv", bus.y_valid, 1'b0);
        tick();
        check("er_gnt_d", bus.gnt, 4'b1000);
        check("er_sel_d", {bus.s1, bus.s0}, 2'b11);
        tick();
        check("er_y_d", bus.y, 8'h44);
        check("er_yv_d", bus.y_valid, 1'b1);

        // Asynchronous reset mid-grant with a beat held in y
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_gnt", bus.gnt, 4'b0000);
        check("ar_sel", {bus.s1, bus.s0}, 2'b00);
        check("ar_y", bus.y, 8'h00);
        check("ar_yv", bus.y_valid, 1'b0);
        check("ar_busy", bus.busy, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        bus.a   = src_data[0];
        bus.req = 4'b1111;

        // Round robin with all four requesting: a,b,c,d,a
        tick();
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 4; k++) begin
                check("rr_gnt", bus.gnt, 4'b0001 << (g % 4));
                tick();
            end
            check("rr_dead", bus.gnt, 4'b0000);
            check("rr_y", bus.y, src_data[g % 4]);
            tick();
        end
        bus.req = 4'b0000;
        tick();
        check("rr_end", bus.gnt, 4'b0000);

`ifdef MUX4_SCHED_LOCK_EN
        // Lock holds the grant beyond HOLD_MAX; unlocking releases after the next beat
        bus.lock = 1'b1;
        bus.req  = 4'b0001;
        tick();
        for (int i = 0; i < 11; i++) begin
            check("lk_gnt", bus.gnt, 4'b0001);
            tick();
        end
        bus.lock = 1'b0;
        tick();
        check("lk_rel", bus.gnt, 4'b0000);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("ul_gnt", bus.gnt, 4'b0001);
            tick();
        end
        check("ul_rel", bus.gnt, 4'b0000);
        bus.req = 4'b0000;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
